// File: rtl/imem_loader.sv
`default_nettype none
// =====================================================================
// Module   : imem_loader
// Purpose  : Loads a program into the instruction RAM from a UART byte
//            stream (length byte, then big-endian words), then hands the
//            RAM read port back to the CPU and releases cpu_run.
// Options  : IMEM_LOADER_CHECKSUM_EN - expect a trailing XOR checksum
//            byte covering the length byte and every data byte.
// Revision : 1.0 - initial release
// =====================================================================
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 24,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  output logic              cpu_run,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int BPW = DATA_W / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [TCW-1:0] LAST_WAIT = TCW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_BYTE  = 3'd2,
    S_WRITE = 3'd3,
    S_WACK  = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TCW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W:0]    words_loaded_q, words_loaded_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic               cpu_run_q, cpu_run_d;
  logic               load_busy_q, load_busy_d;
  logic               load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               xfer;
  logic [ADDR_W:0]    words_inc;

  // Byte handshake is only offered while the FSM is collecting stream bytes
  always_comb begin
    rx_ready = (state_q == S_LEN) || (state_q == S_BYTE) || (state_q == S_CSUM);
  end

  assign xfer         = rx_valid & rx_ready;
  assign words_inc    = words_loaded_q + 1'b1;
  assign ram_we       = (state_q == S_WRITE);
  assign load_done    = (state_q == S_DONE);
  assign ram_addr     = load_busy_q ? ptr_q : cpu_addr;
  assign ram_wdata    = ram_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign load_busy    = load_busy_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

  // Next-state and datapath update for the load sequencer
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    ptr_d          = ptr_q;
    words_loaded_d = words_loaded_q;
    ram_wdata_d    = ram_wdata_q;
    cpu_run_d      = cpu_run_q;
    load_busy_d    = load_busy_q;
    load_err_d     = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d         = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_LEN;
          cpu_run_d      = 1'b0;
          load_busy_d    = 1'b1;
          load_err_d     = 1'b0;
          words_loaded_d = '0;
          ptr_d          = '0;
          byte_cnt_d     = '0;
        end
      end

      S_LEN: begin
        if (xfer) begin
          // A zero length byte stands for a full-depth load
          if (rx_data == 8'd0) begin
            len_d = {1'b1, {ADDR_W{1'b0}}};
          end else begin
            len_d = (ADDR_W+1)'(rx_data);
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = rx_data;
`endif
          state_d = S_BYTE;
        end
      end

      S_BYTE: begin
        if (xfer) begin
          // Bytes arrive MSB first, so shift left and append
          ram_wdata_d = (ram_wdata_q << 8) | DATA_W'(rx_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        tmo_cnt_d = '0;
        state_d   = S_WACK;
      end

      S_WACK: begin
        // An ack in the final allowed cycle still wins over the timeout
        if (ram_ack) begin
          words_loaded_d = words_inc;
          ptr_d          = ptr_q + 1'b1;
          if (words_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_BYTE;
          end
        end else if (tmo_cnt_q == LAST_WAIT) begin
          state_d = S_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      S_DONE: begin
        load_busy_d = 1'b0;
        cpu_run_d   = 1'b1;
        state_d     = S_IDLE;
      end

      S_ERR: begin
        // CPU stays halted after a failed load
        load_err_d  = 1'b1;
        load_busy_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset leaves the CPU running from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      ptr_q          <= '0;
      words_loaded_q <= '0;
      ram_wdata_q    <= '0;
      cpu_run_q      <= 1'b1;
      load_busy_q    <= 1'b0;
      load_err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_cnt_q     <= byte_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      ptr_q          <= ptr_d;
      words_loaded_q <= words_loaded_d;
      ram_wdata_q    <= ram_wdata_d;
      cpu_run_q      <= cpu_run_d;
      load_busy_q    <= load_busy_d;
      load_err_q     <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

endmodule
`default_nettype wire
